// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD message scheduler.
package lcd_pkg;

  localparam int LINE_W = 128;
  localparam logic [LINE_W-1:0] BLANK_LINE = 128'h2020_2020_2020_2020_2020_2020_2020_2020;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// wrapping past the highest source index back to 0.
module lcd_rr_arbiter #(
  parameter int N_SRC = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    cand       = ptr;
    for (int k = 0; k < N_SRC; k++) begin
      if (!any && req[cand]) begin
        any              = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
      cand = (cand == IDX_W'(N_SRC - 1)) ? '0 : cand + IDX_W'(1);
    end
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Time-shares a 16x2 LCD among N_SRC frame sources: round-robin grant, then
// hold the granted frame for DWELL_CYCLES before arbitrating again.
module lcd_msg_scheduler
  import lcd_pkg::*;
#(
  parameter int N_SRC        = 3,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC*LINE_W-1:0] msg_line1,
  input  logic [N_SRC*LINE_W-1:0] msg_line2,
  output logic [N_SRC-1:0]        grant,
  output logic [LINE_W-1:0]       line1,
  output logic [LINE_W-1:0]       line2,
  output logic [2:0]              active_id,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_SRC);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [LINE_W-1:0]  line1_q, line1_d;
  logic [LINE_W-1:0]  line2_q, line2_d;
  logic [2:0]         active_id_q, active_id_d;
  logic               busy_q, busy_d;

  logic [N_SRC-1:0]   win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               any;

  logic [LINE_W-1:0]  src_l1 [N_SRC];
  logic [LINE_W-1:0]  src_l2 [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_l1[i] = msg_line1[i*LINE_W +: LINE_W];
    assign src_l2[i] = msg_line2[i*LINE_W +: LINE_W];
  end

  lcd_rr_arbiter #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any        (any)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    grant_d     = '0;
    line1_d     = line1_q;
    line2_d     = line2_q;
    active_id_d = active_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          grant_d     = win_onehot;
          line1_d     = src_l1[win_idx];
          line2_d     = src_l2[win_idx];
          active_id_d = 3'(win_idx);
          ptr_d       = (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + IDX_W'(1);
          cnt_d       = CNT_W'(DWELL_CYCLES - 1);
          state_d     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        // Requests are deliberately ignored here; the frame stays frozen.
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
    busy_d = (state_d == ST_DWELL);
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      line1_q     <= BLANK_LINE;
      line2_q     <= BLANK_LINE;
      active_id_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      active_id_q <= active_id_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign line1     = line1_q;
  assign line2     = line2_q;
  assign active_id = active_id_q;
  assign busy      = busy_q;

endmodule
